cgra_pkt_s2mm: RTL and testbench
================================

Name: cgra_pkt_s2mm

Overview:
- Stream-to-memory write engine for CGRA result packets.
- Accepts AXIS_W-bit packets from the CGRA bridge send side and writes each one to shared SRAM as an AXI4 INCR write burst of AXI_DATA_W beats.
- Controlled by the MMIO DST_TX / LEN_TX / start_tx registers.
- Forms the memory-write counterpart of the memory-to-CGRA read engine.

Parameters:
- AXI_ADDR_W, 64, AXI address width.
- AXI_DATA_W, 64, AXI data width; must be a power of two ≥ 8.
- AXI_ID_W, 4, AXI ID width.
- AXIS_W, 192, packet stream width; must be a multiple of AXI_DATA_W.
- BEATS_PER_PKT, 3, equals AXIS_W/AXI_DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  level/pulse; sampled only in IDLE
- dst_addr  in  AXI_ADDR_W  destination byte address of packet 0
- len_pkts  in  32  number of packets to write
- busy  out  1  transfer in progress
- done  out  1  sticky completion flag
- err  out  1  sticky; any BRESP ≠ OKAY during current job
- pkts_done  out  32  packets fully acknowledged in current job
- s_axis_tdata  in  AXIS_W  packet data
- s_axis_tvalid  in  1  packet valid
- s_axis_tready  out  1  packet accept
- awid  out  AXI_ID_W  always 0
- awaddr  out  AXI_ADDR_W  burst address
- awlen  out  8  beats − 1
- awsize  out  3  log2(AXI_DATA_W/8)
- awburst  out  2  2'b01 (INCR)
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wdata  out  AXI_DATA_W  write data
- wstrb  out  AXI_DATA_W/8  all ones
- wlast  out  1  last beat of burst
- wvalid  out  1  W valid
- wready  in  1  W ready
- bid  in  AXI_ID_W  ignored
- bresp  in  2  write response
- bvalid  in  1  B valid
- bready  out  1  B ready

Behaviour:

Reset:
- While rst=1, all outputs are 0 and the FSM is IDLE.
- rst mid-job abandons the job immediately. No further AW/W/B handshakes occur, and any in-flight AXI transaction is lost.

States: IDLE, GET, AW, W, B.

IDLE:
- On start=1, latch cur_addr = {dst_addr[AXI_ADDR_W-1:3], 3'b0} (low bits forced to 0) and remaining = len_pkts.
- Clear done, err, pkts_done.
- If len_pkts=0: set done=1 next cycle and stay in IDLE; busy never asserts.
- Otherwise set busy=1 next cycle and go to GET.
- start while busy=1 is ignored.

GET:
- s_axis_tready=1 only in this state.
- On tvalid&tready, capture tdata into the packet buffer, set beat_idx=0, go to AW.

AW:
- awaddr = cur_addr.
- beats_this = min(BEATS_PER_PKT − beat_idx, (4096 − cur_addr[11:0]) / (AXI_DATA_W/8)), so no burst crosses a 4 KB boundary.
- awlen = beats_this − 1.
- awvalid holds until awready; signals are stable while awvalid=1. Then go to W.

W:
- wdata = buffer[beat_idx*AXI_DATA_W +: AXI_DATA_W] (LSB beat first).
- wvalid=1; each wready handshake increments beat_idx and cur_addr by AXI_DATA_W/8.
- wlast=1 on the final beat of the current burst.
- After the wlast handshake go to B.

B:
- bready=1.
- On bvalid, set err|=(bresp≠2'b00). The job is not aborted.
- If beat_idx<BEATS_PER_PKT (split packet), go to AW for the remainder.
- Otherwise increment pkts_done and decrement remaining.
  - If remaining becomes 0: busy=0, done=1, go to IDLE.
  - Otherwise go to GET.

Ordering and timing:
- Exactly one outstanding burst at a time.
- AW precedes W; W is never asserted before the AW handshake.
- Packet stride in memory is BEATS_PER_PKT*AXI_DATA_W/8 bytes (24 by default). Packets are contiguous, and splitting does not change the layout.
- Minimum latency per unsplit packet, with all readies held high: 1 (GET) + 1 (AW) + BEATS_PER_PKT (W) + 1 (B) = 6 cycles.
- done stays 1 until the next accepted start.
- cur_addr wraps modulo 2^AXI_ADDR_W with no error.

Test Plan:
1. dst_addr=0x1000, len_pkts=2, readies tied high, packets P0/P1 with distinct 64-bit lanes -> two AW at 0x1000 and 0x1018 with awlen=2, awsize=3, awburst=1. Beats are lanes 0,1,2 in order with wlast on the 3rd. done=1 and pkts_done=2 after the 2nd B. Packet period is 6 cycles.
2. dst_addr=0x0FF0, len_pkts=1 -> AW 0x0FF0 awlen=1 (beats 0,1, wlast on beat 1), B, then AW 0x1000 awlen=0 (beat 2, wlast). pkts_done=1.
3. len_pkts=0 with start=1 -> done=1 one cycle later, busy never 1, no AW/W activity.
4. Random backpressure on tvalid/awready/wready/bvalid, len_pkts=5, dst_addr=0x2003 -> writes at 0x2000+24k for k=0..4. awaddr/awlen stable while awvalid=1 and not ready. wdata stable while wvalid=1 and not ready. Memory image matches the packets.
5. bresp=2'b10 on the 2nd of 3 packets -> err=1 sticky, all 3 packets still written, done=1, pkts_done=3. A new start clears err.
6. Assert rst during W of packet 1 of 4 -> all outputs 0 the same cycle. After release, start with len_pkts=1 completes normally with pkts_done=1.

Source files
------------

// File: rtl/cgra_pkt_s2mm.sv
// cgra_pkt_s2mm: writes CGRA result packets from an AXI-Stream into
// memory as AXI4 INCR bursts, one outstanding, never crossing 4 KB.
module cgra_pkt_s2mm #(
   parameter int AXI_ADDR_W    = 64,
   parameter int AXI_DATA_W    = 64,
   parameter int AXI_ID_W      = 4,
   parameter int AXIS_W        = 192,
   parameter int BEATS_PER_PKT = AXIS_W / AXI_DATA_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [AXI_ADDR_W-1:0]   dst_addr,
   input  logic [31:0]             len_pkts,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [31:0]             pkts_done,
   input  logic [AXIS_W-1:0]       s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [AXI_ID_W-1:0]     awid,
   output logic [AXI_ADDR_W-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [AXI_DATA_W-1:0]   wdata,
   output logic [AXI_DATA_W/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [AXI_ID_W-1:0]     bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready
);

   localparam int BYTES = AXI_DATA_W / 8;
   localparam int SZ    = $clog2(BYTES);
   localparam int BW    = $clog2(BEATS_PER_PKT + 1);
   localparam int CW    = 13;
   localparam logic [AXI_ADDR_W-1:0] LOW_MASK = AXI_ADDR_W'(BYTES - 1);

   typedef enum logic [2:0] {IDLE, GET, AW, W, B} state_t;

   state_t                state;
   logic [AXI_ADDR_W-1:0] cur_addr;
   logic [31:0]           remaining;
   logic [AXIS_W-1:0]     pkt_buf;
   logic [BW-1:0]         beat_idx;
   logic [7:0]            burst_left;
   logic [CW-1:0]         beats_left;
   logic [CW-1:0]         room;
   logic [CW-1:0]         beats_this;
   logic                  unused_bid;

   assign unused_bid = ^bid;

   // Burst length: rest of the packet, clipped at the next 4 KB page.
   always_comb begin
      beats_left = CW'(BEATS_PER_PKT) - CW'(beat_idx);
      room       = (CW'(4096) - CW'(cur_addr[11:0])) >> SZ;
      beats_this = (beats_left < room) ? beats_left : room;
   end

   assign busy          = (state != IDLE);
   assign s_axis_tready = (state == GET);
   assign awvalid       = (state == AW);
   assign wvalid        = (state == W);
   assign bready        = (state == B);

   assign awid    = '0;
   assign awaddr  = awvalid ? cur_addr : '0;
   assign awlen   = awvalid ? 8'(beats_this - CW'(1)) : 8'd0;
   assign awsize  = awvalid ? 3'(SZ) : 3'd0;
   assign awburst = awvalid ? 2'b01 : 2'b00;
   assign wdata   = wvalid ? pkt_buf[AXI_DATA_W-1:0] : '0;
   assign wstrb   = wvalid ? '1 : '0;
   assign wlast   = wvalid && (burst_left == 8'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cur_addr   <= '0;
         remaining  <= '0;
         pkt_buf    <= '0;
         beat_idx   <= '0;
         burst_left <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         pkts_done  <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               cur_addr  <= dst_addr & ~LOW_MASK;
               remaining <= len_pkts;
               err       <= 1'b0;
               pkts_done <= '0;
               done      <= (len_pkts == 32'd0);
               if (len_pkts != 32'd0) state <= GET;
            end
            GET: if (s_axis_tvalid) begin
               pkt_buf  <= s_axis_tdata;
               beat_idx <= '0;
               state    <= AW;
            end
            AW: if (awready) begin
               burst_left <= 8'(beats_this);
               state      <= W;
            end
            // The buffer shifts down so the next beat is always in the low lane.
            W: if (wready) begin
               pkt_buf    <= pkt_buf >> AXI_DATA_W;
               beat_idx   <= beat_idx + 1'b1;
               cur_addr   <= cur_addr + AXI_ADDR_W'(BYTES);
               burst_left <= burst_left - 8'd1;
               if (wlast) state <= B;
            end
            B: if (bvalid) begin
               err <= err | (bresp != 2'b00);
               if (beat_idx < BW'(BEATS_PER_PKT)) begin
                  state <= AW;
               end else begin
                  pkts_done <= pkts_done + 32'd1;
                  remaining <= remaining - 32'd1;
                  if (remaining == 32'd1) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= GET;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cgra_pkt_s2mm.sv
// Bench for cgra_pkt_s2mm: a table of jobs checked against a packet-level
// memory/burst model, with a randomising AXI slave and AXIS source.
`timescale 1ns/1ps
module tb_cgra_pkt_s2mm;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [63:0]  dst_addr;
   logic [31:0]  len_pkts;
   logic         busy, done, err;
   logic [31:0]  pkts_done;
   logic [191:0] s_axis_tdata;
   logic         s_axis_tvalid, s_axis_tready;
   logic [3:0]   awid;
   logic [63:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         awvalid, awready;
   logic [63:0]  wdata;
   logic [7:0]   wstrb;
   logic         wlast, wvalid, wready;
   logic [3:0]   bid;
   logic [1:0]   bresp;
   logic         bvalid, bready;

   always #5 clk = ~clk;

   cgra_pkt_s2mm dut (
      .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr),
      .len_pkts(len_pkts), .busy(busy), .done(done), .err(err),
      .pkts_done(pkts_done), .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
      .bready(bready)
   );

   typedef struct {
      logic [63:0] dst;
      int          len;
      bit          bp;
      int          bad;
      bit          exp_err;
      int          period;
   } job_t;

   int checks = 0;
   int errors = 0;

   logic [191:0] pkt_q[$];
   logic [71:0]  aw_log[$];
   int           aw_cyc[$];
   logic [63:0]  mem[logic [63:0]];
   int           tx_idx = 0, pending = 0, b_cnt = 0, bad_burst = -1, cyc = 0;
   bit           bp_mode = 0, saw_busy = 0, saw_w = 0;
   bit           aw_open = 0, aw_hold = 0, w_hold = 0;
   logic [63:0]  w_addr, aw_held_addr, w_held_data;
   logic [7:0]   aw_held_len;
   logic         w_held_last;
   int           w_beat = 0, w_len = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endfunction

   function automatic job_t mk(logic [63:0] d, int n, bit bp, int bad, bit e, int per);
      job_t j;
      j.dst = d; j.len = n; j.bp = bp; j.bad = bad; j.exp_err = e; j.period = per;
      return j;
   endfunction

   // AXI slave monitor: samples at negedge what the next posedge will see.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         aw_open = 0; pending = 0; aw_hold = 0; w_hold = 0;
      end else begin
         if (busy) saw_busy = 1;
         if (wvalid) saw_w = 1;
         if (aw_hold) begin
            chk("aw_hold_valid", 64'(awvalid), 64'd1);
            chk("aw_hold_addr", awaddr, aw_held_addr);
            chk("aw_hold_len", 64'(awlen), 64'(aw_held_len));
         end
         if (w_hold) begin
            chk("w_hold_valid", 64'(wvalid), 64'd1);
            chk("w_hold_data", wdata, w_held_data);
            chk("w_hold_last", 64'(wlast), 64'(w_held_last));
         end
         if (wvalid) chk("w_after_aw", 64'(aw_open), 64'd1);
         if (wvalid && wready && aw_open) begin
            mem[w_addr] = wdata;
            chk("wlast", 64'(wlast), 64'(w_beat == w_len));
            chk("wstrb", 64'(wstrb), 64'hff);
            w_addr = w_addr + 64'd8;
            if (w_beat == w_len) begin
               aw_open = 0;
               pending++;
            end
            w_beat++;
         end
         if (awvalid && awready) begin
            chk("aw_one_open", 64'(aw_open), 64'd0);
            chk("awsize", 64'(awsize), 64'd3);
            chk("awburst", 64'(awburst), 64'd1);
            chk("awid", 64'(awid), 64'd0);
            aw_log.push_back({awaddr, awlen});
            aw_cyc.push_back(cyc);
            w_addr = awaddr; w_beat = 0; w_len = int'(awlen); aw_open = 1;
         end
         if (bvalid && bready) begin
            pending--;
            b_cnt++;
         end
         if (s_axis_tvalid && s_axis_tready) tx_idx++;
         aw_hold = awvalid && !awready;
         aw_held_addr = awaddr; aw_held_len = awlen;
         w_hold = wvalid && !wready;
         w_held_data = wdata; w_held_last = wlast;
      end
   end

   // Stimulus driver: readies, packet source and B responder.
   initial begin
      s_axis_tvalid = 0; s_axis_tdata = '0; awready = 0; wready = 0;
      bvalid = 0; bresp = 2'b00; bid = '0;
      forever begin
         @(posedge clk); #1;
         awready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         wready  = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (tx_idx < pkt_q.size()) begin
            s_axis_tdata  = pkt_q[tx_idx];
            s_axis_tvalid = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         end else begin
            s_axis_tvalid = 1'b0;
         end
         bvalid = (pending > 0) && (bp_mode ? 1'($urandom_range(0, 1)) : 1'b1);
         bresp  = (b_cnt == bad_burst) ? 2'b10 : 2'b00;
      end
   end

   task automatic prep(input logic [63:0] d, input int n, input bit bp, input int bad);
      pkt_q.delete();
      for (int k = 0; k < n; k++)
         pkt_q.push_back({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      tx_idx = 0; b_cnt = 0; bad_burst = bad; bp_mode = bp;
      aw_log.delete(); aw_cyc.delete(); mem.delete();
      dst_addr = d; len_pkts = 32'(n);
   endtask

   task automatic kick();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic check_outs_zero(input string tag);
      chk({tag, "_ctl"}, 64'({busy, done, err, s_axis_tready, awvalid, wvalid, wlast, bready}), 64'd0);
      chk({tag, "_pkts"}, 64'(pkts_done), 64'd0);
      chk({tag, "_awaddr"}, awaddr, 64'd0);
      chk({tag, "_wdata"}, wdata, 64'd0);
      chk({tag, "_misc"}, 64'({awid, awlen, awsize, awburst, wstrb}), 64'd0);
   endtask

   task automatic run_job(input job_t j);
      logic [71:0] exp_aw[$];
      logic [63:0] a;
      int left, room, nb;
      prep(j.dst, j.len, j.bp, j.bad);
      kick();
      @(negedge clk);
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_done_clr", 64'(done), 64'd0);
      chk("start_err_clr", 64'(err), 64'd0);
      for (int c = 0; c < 2000 && !done; c++) @(negedge clk);
      chk("job_done", 64'(done), 64'd1);
      chk("job_busy_off", 64'(busy), 64'd0);
      chk("job_pkts_done", 64'(pkts_done), 64'(j.len));
      chk("job_err", 64'(err), 64'(j.exp_err));
      // Burst model: walk the packets' byte range, clipping at 4 KB pages.
      a = j.dst & ~64'h7;
      for (int k = 0; k < j.len; k++) begin
         left = 3;
         while (left > 0) begin
            room = (4096 - int'(a[11:0])) / 8;
            nb = (left < room) ? left : room;
            exp_aw.push_back({a, 8'(nb - 1)});
            a = a + 64'(8 * nb);
            left = left - nb;
         end
      end
      chk("aw_count", 64'(aw_log.size()), 64'(exp_aw.size()));
      for (int i = 0; i < exp_aw.size() && i < aw_log.size(); i++) begin
         chk("aw_addr", aw_log[i][71:8], exp_aw[i][71:8]);
         chk("aw_len", 64'(aw_log[i][7:0]), 64'(exp_aw[i][7:0]));
      end
      for (int k = 0; k < j.len; k++)
         for (int b = 0; b < 3; b++) begin
            a = (j.dst & ~64'h7) + 64'(24 * k + 8 * b);
            chk("mem_word", mem.exists(a) ? mem[a] : ~pkt_q[k][b*64 +: 64],
                pkt_q[k][b*64 +: 64]);
         end
      if (j.period > 0 && aw_cyc.size() >= 2)
         chk("pkt_period", 64'(aw_cyc[1] - aw_cyc[0]), 64'(j.period));
   endtask

   job_t tbl[10];

   initial begin
      tbl[0] = mk(64'h1000, 2, 0, -1, 0, 6);
      tbl[1] = mk(64'h0FF0, 1, 0, -1, 0, 0);
      tbl[2] = mk(64'h2003, 5, 1, -1, 0, 0);
      tbl[3] = mk(64'h3000, 3, 0, 1, 1, 0);
      tbl[4] = mk(64'h3100, 2, 0, -1, 0, 0);
      tbl[5] = mk(64'hFFFF_FFFF_FFFF_FFF0, 1, 0, -1, 0, 0);
      for (int i = 6; i < 10; i++)
         tbl[i] = mk({$urandom, $urandom}, int'($urandom_range(1, 6)), 1'b1, -1, 0, 0);

      start = 0; dst_addr = '0; len_pkts = '0;
      rst = 0;
      #1 rst = 1;
      repeat (3) @(negedge clk);
      check_outs_zero("reset");
      #2 rst = 0;

      // Zero-length job: done next cycle, never busy, no bus activity.
      @(negedge clk);
      prep(64'h100, 0, 0, -1);
      saw_busy = 0; saw_w = 0;
      kick();
      @(negedge clk);
      chk("len0_done", 64'(done), 64'd1);
      chk("len0_busy", 64'(busy), 64'd0);
      repeat (5) @(negedge clk);
      chk("len0_never_busy", 64'(saw_busy), 64'd0);
      chk("len0_no_aw", 64'(aw_log.size()), 64'd0);
      chk("len0_no_w", 64'(saw_w), 64'd0);

      for (int i = 0; i < 10; i++) run_job(tbl[i]);

      // Reset in the middle of packet 1's W phase, then a clean job.
      prep(64'h6000, 4, 0, -1);
      kick();
      for (int c = 0; c < 200 && !(aw_log.size() == 2 && wvalid); c++)
         @(negedge clk);
      chk("rst_reach_w", 64'(aw_log.size() == 2 && wvalid), 64'd1);
      #1 rst = 1;
      pending = 0;
      #1 check_outs_zero("midrst");
      @(negedge clk);
      #2 rst = 0;
      run_job(mk(64'h7000, 1, 0, -1, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
